// File: rtl/pong_pkg.sv
// Shared constants, state encoding and helpers for the pong physics engine.
package pong_pkg;

  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_BALL_SIZE   = 8;
  localparam int DEF_PADDLE_W    = 64;
  localparam int DEF_PADDLE_Y    = 460;
  localparam int DEF_PADDLE_STEP = 8;
  localparam int DEF_BALL_SPEED  = 2;
  localparam int DEF_FRAME_DIV   = 833333;

  localparam int BALL_X_MAX   = DEF_SCREEN_W - DEF_BALL_SIZE;
  localparam int PADDLE_X_MAX = DEF_SCREEN_W - DEF_PADDLE_W;

  // IDLE wait for arm | ARMED wait for start | RUN play | DEAD wait for re-arm
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pong_engine_frame_tick_gen.sv
// Free-running modulo counter; o_tick is high while the count sits at FRAME_DIV-1.
module frame_tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == C_LAST);

endmodule

// File: rtl/pong_engine.sv
// Pong game physics: paddle, ball, score and miss detection, stepped once per frame tick.
module pong_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int BALL_SIZE   = DEF_BALL_SIZE,
  parameter int PADDLE_W    = DEF_PADDLE_W,
  parameter int PADDLE_Y    = DEF_PADDLE_Y,
  parameter int PADDLE_STEP = DEF_PADDLE_STEP,
  parameter int BALL_SPEED  = DEF_BALL_SPEED,
  parameter int FRAME_DIV   = DEF_FRAME_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ready_sig,
  input  logic       i_start_sig,
  input  logic       i_play_sig,
  input  logic       i_pause_sig,
  input  logic       i_left_sig,
  input  logic       i_right_sig,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic [9:0] o_paddle_x,
  output logic [7:0] o_score,
  output logic       o_sig_dead,
  output logic       o_running
);

  localparam logic [9:0] C_BX_INIT = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0] C_BY_INIT = 10'(SCREEN_H / 2);
  localparam logic [9:0] C_PX_INIT = 10'(SCREEN_W / 2 - PADDLE_W / 2);
  localparam logic [9:0] C_BY_HIT  = 10'(PADDLE_Y - BALL_SIZE);
  localparam logic [9:0] C_SPD_U   = 10'(BALL_SPEED);

  localparam logic signed [10:0] C_SPD   = 11'(BALL_SPEED);
  localparam logic signed [10:0] C_STEP  = 11'(PADDLE_STEP);
  localparam logic signed [10:0] C_BSZ   = 11'(BALL_SIZE);
  localparam logic signed [10:0] C_PW    = 11'(PADDLE_W);
  localparam logic signed [10:0] C_PY    = 11'(PADDLE_Y);
  localparam logic signed [10:0] C_BXMAX = 11'(SCREEN_W - BALL_SIZE);
  localparam logic signed [10:0] C_PXMAX = 11'(SCREEN_W - PADDLE_W);

  state_t     r_state, w_state_nxt;
  logic [9:0] r_ball_x, r_ball_y, r_paddle_x;
  logic [9:0] w_bx_nxt, w_by_nxt, w_px_nxt;
  logic [7:0] r_score, w_score_nxt;
  logic       r_dx, r_dy, w_dx_nxt, w_dy_nxt;
  logic       r_left_req, r_right_req, w_lreq_nxt, w_rreq_nxt;
  logic       r_sig_dead, w_dead_nxt;
  logic       w_tick, w_left, w_right;

  logic signed [10:0] w_bx_s, w_by_s, w_px_s, w_bx_step, w_by_dn, w_px_l, w_px_r;
  logic [9:0] w_bx_new, w_by_new, w_px_new;
  logic       w_dx_new, w_dy_new, w_floor, w_hit, w_catch, w_miss;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  // A request raised on the tick cycle itself still counts for that tick.
  assign w_left  = r_left_req | i_left_sig;
  assign w_right = r_right_req | i_right_sig;

  assign w_bx_s    = $signed({1'b0, r_ball_x});
  assign w_by_s    = $signed({1'b0, r_ball_y});
  assign w_px_s    = $signed({1'b0, r_paddle_x});
  assign w_bx_step = w_bx_s + (r_dx ? C_SPD : -C_SPD);
  assign w_by_dn   = w_by_s + C_SPD;
  assign w_px_l    = w_px_s - C_STEP;
  assign w_px_r    = w_px_s + C_STEP;
  assign w_hit     = (w_bx_s + C_BSZ > w_px_s) && (w_bx_s < w_px_s + C_PW);
  assign w_catch   = w_floor && w_hit;
  assign w_miss    = w_floor && !w_hit;

  always_comb begin
    w_px_new = r_paddle_x;
    if (w_left && !w_right) begin
      w_px_new = w_px_l[10] ? 10'd0 : w_px_l[9:0];
    end else if (w_right && !w_left) begin
      w_px_new = (w_px_r > C_PXMAX) ? C_PXMAX[9:0] : w_px_r[9:0];
    end

    w_dx_new = r_dx;
    w_bx_new = w_bx_step[9:0];
    if (w_bx_step >= C_BXMAX) begin
      w_bx_new = C_BXMAX[9:0];
      w_dx_new = 1'b0;
    end else if (w_bx_step[10]) begin
      w_bx_new = 10'd0;
      w_dx_new = 1'b1;
    end

    w_dy_new = r_dy;
    w_by_new = r_ball_y;
    w_floor  = 1'b0;
    if (!r_dy) begin
      if (w_by_s <= C_SPD) begin
        w_by_new = 10'd0;
        w_dy_new = 1'b1;
      end else begin
        w_by_new = r_ball_y - C_SPD_U;
      end
    end else begin
      w_by_new = w_by_dn[9:0];
      if (w_by_dn + C_BSZ >= C_PY) begin
        w_floor = 1'b1;
        if (w_hit) begin
          w_by_new = C_BY_HIT;
          w_dy_new = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bx_nxt    = r_ball_x;
    w_by_nxt    = r_ball_y;
    w_px_nxt    = r_paddle_x;
    w_dx_nxt    = r_dx;
    w_dy_nxt    = r_dy;
    w_score_nxt = r_score;
    w_dead_nxt  = 1'b0;
    w_lreq_nxt  = w_tick ? 1'b0 : w_left;
    w_rreq_nxt  = w_tick ? 1'b0 : w_right;
    if (i_ready_sig) begin
      w_state_nxt = ST_ARMED;
      w_bx_nxt    = C_BX_INIT;
      w_by_nxt    = C_BY_INIT;
      w_px_nxt    = C_PX_INIT;
      w_dx_nxt    = 1'b1;
      w_dy_nxt    = 1'b1;
      w_score_nxt = 8'd0;
      w_lreq_nxt  = 1'b0;
      w_rreq_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_ARMED: if (i_start_sig) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (w_tick && i_play_sig && !i_pause_sig) begin
            w_bx_nxt = w_bx_new;
            w_by_nxt = w_by_new;
            w_px_nxt = w_px_new;
            w_dx_nxt = w_dx_new;
            w_dy_nxt = w_dy_new;
            if (w_catch) w_score_nxt = sat_inc8(r_score);
            if (w_miss) begin
              w_dead_nxt  = 1'b1;
              w_state_nxt = ST_DEAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ball_x    <= C_BX_INIT;
      r_ball_y    <= C_BY_INIT;
      r_paddle_x  <= C_PX_INIT;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_score     <= 8'd0;
      r_sig_dead  <= 1'b0;
      r_left_req  <= 1'b0;
      r_right_req <= 1'b0;
    end else begin
      r_ball_x    <= w_bx_nxt;
      r_ball_y    <= w_by_nxt;
      r_paddle_x  <= w_px_nxt;
      r_dx        <= w_dx_nxt;
      r_dy        <= w_dy_nxt;
      r_score     <= w_score_nxt;
      r_sig_dead  <= w_dead_nxt;
      r_left_req  <= w_lreq_nxt;
      r_right_req <= w_rreq_nxt;
    end
  end

  assign o_ball_x   = r_ball_x;
  assign o_ball_y   = r_ball_y;
  assign o_paddle_x = r_paddle_x;
  assign o_score    = r_score;
  assign o_sig_dead = r_sig_dead;
  assign o_running  = (r_state == ST_RUN);

endmodule

// File: tb/tb_pong_engine.sv
// Self-checking bench for pong_engine: vector table, cycle scoreboard against a reference model, and scripted game scenarios.
module tb_pong_engine;

  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_ready_sig, i_start_sig, i_play_sig, i_pause_sig, i_left_sig, i_right_sig;
  logic [9:0] o_ball_x, o_ball_y, o_paddle_x;
  logic [7:0] o_score;
  logic       o_sig_dead, o_running;

  pong_engine #(.FRAME_DIV(FD)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_ready_sig (i_ready_sig),
    .i_start_sig (i_start_sig),
    .i_play_sig  (i_play_sig),
    .i_pause_sig (i_pause_sig),
    .i_left_sig  (i_left_sig),
    .i_right_sig (i_right_sig),
    .o_ball_x    (o_ball_x),
    .o_ball_y    (o_ball_y),
    .o_paddle_x  (o_paddle_x),
    .o_score     (o_score),
    .o_sig_dead  (o_sig_dead),
    .o_running   (o_running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] px;
    logic [7:0] sc;
    logic       dead;
    logic       run;
  } outs_t;

  typedef struct {
    bit rdy, st, pl, pa, le, ri;
    int bx, by, px, sc;
    bit dead, run;
  } vec_t;

  vec_t  vt [16];
  outs_t exp_q [$];
  int    checks = 0;
  int    failures = 0;

  // reference model state (directions: +1 right/down, -1 left/up)
  int m_cnt, m_state, m_bx, m_by, m_px, m_sc, m_dx, m_dy;
  bit m_l, m_r, m_dead;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_init(input bit full);
    if (full) begin
      m_cnt = 0;
      m_state = 0;
    end else begin
      m_state = 1;
    end
    m_bx = 316; m_by = 240; m_px = 288; m_sc = 0;
    m_dx = 1; m_dy = 1; m_l = 0; m_r = 0; m_dead = 0;
  endtask

  function automatic outs_t model_outs();
    outs_t o;
    o.bx = 10'(m_bx); o.by = 10'(m_by); o.px = 10'(m_px); o.sc = 8'(m_sc);
    o.dead = m_dead; o.run = (m_state == 2);
    return o;
  endfunction

  task automatic model_cycle(input bit rdy, st, pl, pa, le, ri);
    bit tick, l, r;
    int s, nx, ny, npx, ndx, ndy;
    tick = (m_cnt == FD - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    m_dead = 0;
    if (rdy) begin
      model_init(0);
    end else begin
      l = m_l | le;
      r = m_r | ri;
      m_l = tick ? 1'b0 : l;
      m_r = tick ? 1'b0 : r;
      s = m_state;
      if (s == 1 && st) m_state = 2;
      if (s == 2 && tick && pl && !pa) begin
        npx = m_px;
        if (l && !r) npx = (m_px - 8 < 0) ? 0 : m_px - 8;
        if (r && !l) npx = (m_px + 8 > 576) ? 576 : m_px + 8;
        ndx = m_dx;
        nx = m_bx + 2 * m_dx;
        if (nx >= 632) begin nx = 632; ndx = -1; end
        else if (nx < 0) begin nx = 0; ndx = 1; end
        ndy = m_dy;
        if (m_dy < 0) begin
          if (m_by <= 2) begin ny = 0; ndy = 1; end
          else ny = m_by - 2;
        end else begin
          ny = m_by + 2;
          if (ny + 8 >= 460) begin
            if (m_bx + 8 > m_px && m_bx < m_px + 64) begin
              ny = 452; ndy = -1;
              if (m_sc < 255) m_sc++;
            end else begin
              m_dead = 1; m_state = 3;
            end
          end
        end
        m_px = npx; m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
      end
    end
  endtask

  task automatic step(input bit rdy, st, pl, pa, le, ri);
    outs_t e, a;
    i_ready_sig = rdy; i_start_sig = st; i_play_sig = pl;
    i_pause_sig = pa; i_left_sig = le; i_right_sig = ri;
    model_cycle(rdy, st, pl, pa, le, ri);
    exp_q.push_back(model_outs());
    @(posedge clk);
    #1;
    a = {o_ball_x, o_ball_y, o_paddle_x, o_score, o_sig_dead, o_running};
    e = exp_q.pop_front();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL cycle t=%0t actual bx=%0d by=%0d px=%0d sc=%0d dead=%0b run=%0b expected bx=%0d by=%0d px=%0d sc=%0d dead=%0b run=%0b",
               $time, a.bx, a.by, a.px, a.sc, a.dead, a.run, e.bx, e.by, e.px, e.sc, e.dead, e.run);
    end
  endtask

  task automatic run_ticks(input int n, input bit pl, pa, le, ri);
    int t = 0;
    while (t < n) begin
      if (m_cnt == FD - 1) t++;
      step(0, 0, pl, pa, le, ri);
    end
  endtask

  task automatic run_rand(input int n);
    int t = 0;
    while (t < n) begin
      if (m_cnt == FD - 1) t++;
      step(0, 0, 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic to_tick_cycle();
    while (m_cnt != FD - 1) step(0, 0, 1, 0, 0, 0);
  endtask

  task automatic chk_pos(input string tag, input int bx, by, px);
    chk({tag, ".bx"}, o_ball_x, bx);
    chk({tag, ".by"}, o_ball_y, by);
    chk({tag, ".px"}, o_paddle_x, px);
  endtask

  initial begin
    reset = 1'b1;
    i_ready_sig = 0; i_start_sig = 0; i_play_sig = 0;
    i_pause_sig = 0; i_left_sig = 0; i_right_sig = 0;
    model_init(1);

    //            rdy st pl pa le ri  bx   by   px  sc dead run
    vt[0]  = '{1, 0, 0, 0, 0, 0, 316, 240, 288, 0, 0, 0};
    vt[1]  = '{0, 1, 1, 0, 0, 0, 316, 240, 288, 0, 0, 1};
    vt[2]  = '{0, 0, 1, 0, 0, 0, 316, 240, 288, 0, 0, 1};
    vt[3]  = '{0, 0, 1, 0, 0, 0, 318, 242, 288, 0, 0, 1};
    vt[4]  = '{0, 0, 1, 0, 0, 0, 318, 242, 288, 0, 0, 1};
    vt[5]  = '{0, 0, 1, 0, 0, 1, 318, 242, 288, 0, 0, 1};
    vt[6]  = '{0, 0, 1, 0, 0, 0, 318, 242, 288, 0, 0, 1};
    vt[7]  = '{0, 0, 1, 0, 0, 0, 320, 244, 296, 0, 0, 1};
    vt[8]  = '{0, 0, 1, 0, 0, 0, 320, 244, 296, 0, 0, 1};
    vt[9]  = '{0, 0, 1, 0, 0, 0, 320, 244, 296, 0, 0, 1};
    vt[10] = '{0, 0, 1, 0, 0, 0, 320, 244, 296, 0, 0, 1};
    vt[11] = '{0, 0, 1, 1, 0, 0, 320, 244, 296, 0, 0, 1};
    vt[12] = '{0, 0, 1, 0, 0, 0, 320, 244, 296, 0, 0, 1};
    vt[13] = '{0, 0, 1, 0, 0, 0, 320, 244, 296, 0, 0, 1};
    vt[14] = '{0, 0, 1, 0, 0, 0, 320, 244, 296, 0, 0, 1};
    vt[15] = '{0, 0, 1, 0, 1, 0, 322, 246, 288, 0, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk_pos("reset", 316, 240, 288);
    chk("reset.score", o_score, 0);
    chk("reset.dead", o_sig_dead, 0);
    chk("reset.running", o_running, 0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(vt[i].rdy, vt[i].st, vt[i].pl, vt[i].pa, vt[i].le, vt[i].ri);
      chk($sformatf("vec%0d.bx", i), o_ball_x, vt[i].bx);
      chk($sformatf("vec%0d.by", i), o_ball_y, vt[i].by);
      chk($sformatf("vec%0d.px", i), o_paddle_x, vt[i].px);
      chk($sformatf("vec%0d.sc", i), o_score, vt[i].sc);
      chk($sformatf("vec%0d.dead", i), o_sig_dead, vt[i].dead);
      chk($sformatf("vec%0d.run", i), o_running, vt[i].run);
    end

    // Hold right the whole game: paddle saturates, ball misses at tick 106.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    run_ticks(100, 1, 0, 0, 1);
    chk_pos("sat100", 516, 440, 576);
    run_ticks(5, 1, 0, 0, 1);
    chk_pos("pre_miss", 526, 450, 576);
    run_ticks(1, 1, 0, 0, 1);
    chk("miss.dead", o_sig_dead, 1);
    chk("miss.running", o_running, 0);
    chk_pos("miss", 528, 452, 576);
    step(0, 0, 1, 0, 0, 1);
    chk("miss.dead_one_cycle", o_sig_dead, 0);
    run_ticks(10, 1, 0, 0, 1);
    chk_pos("dead_frozen", 528, 452, 576);
    chk("dead_frozen.dead", o_sig_dead, 0);

    // Re-arm from DEAD, steer under the ball, catch it, then bounce off the right wall.
    step(1, 0, 0, 0, 0, 0);
    chk_pos("rearm", 316, 240, 288);
    chk("rearm.score", o_score, 0);
    chk("rearm.running", o_running, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("start.running", o_running, 1);
    run_ticks(25, 1, 0, 0, 1);
    chk("steer.px", o_paddle_x, 488);
    run_ticks(81, 1, 0, 0, 0);
    chk_pos("hit", 528, 452, 488);
    chk("hit.score", o_score, 1);
    chk("hit.dead", o_sig_dead, 0);
    chk("hit.running", o_running, 1);
    run_ticks(52, 1, 0, 0, 0);
    chk_pos("wall", 632, 348, 488);
    run_ticks(1, 1, 0, 0, 0);
    chk_pos("wall_back", 630, 346, 488);

    run_ticks(5, 0, 0, 1, 0);
    chk_pos("play_low", 630, 346, 488);
    run_ticks(5, 1, 1, 1, 0);
    chk_pos("paused", 630, 346, 488);
    chk("paused.running", o_running, 1);

    to_tick_cycle();
    step(0, 0, 1, 0, 1, 0);
    chk_pos("left_on_tick", 628, 344, 480);

    run_rand(150);

    // Re-arm coincident with a tick discards the tick.
    to_tick_cycle();
    step(1, 0, 1, 0, 0, 1);
    chk_pos("ready_on_tick", 316, 240, 288);
    chk("ready_on_tick.score", o_score, 0);
    chk("ready_on_tick.running", o_running, 0);
    step(0, 1, 1, 0, 0, 0);
    run_ticks(1, 1, 0, 0, 0);
    chk_pos("after_rearm_tick", 318, 242, 288);

    // Asynchronous reset mid-game.
    run_ticks(3, 1, 0, 0, 1);
    reset = 1'b1;
    #2;
    chk_pos("async_reset", 316, 240, 288);
    chk("async_reset.running", o_running, 0);
    chk("async_reset.score", o_score, 0);
    model_init(1);
    reset = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    run_ticks(1, 1, 0, 0, 0);
    chk_pos("post_reset_tick", 318, 242, 288);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_engine.md
# pong_engine

Game-physics responder for the pong controller's command interface. Consumes the controller's `ready_sig`, `start_sig`, `play_sig`, `pause_sig`, `left_sig` and `right_sig`, and owns paddle and ball position and score. Returns a one-cycle `sig_dead` pulse when the ball passes the paddle. Sits between the game controller and the VGA renderer, which reads `ball_x`, `ball_y` and `paddle_x`.

## Interface

**Parameters**
- `SCREEN_W`, 640: playfield width in pixels.
- `SCREEN_H`, 480: playfield height in pixels.
- `BALL_SIZE`, 8: ball edge length in pixels.
- `PADDLE_W`, 64: paddle width in pixels.
- `PADDLE_Y`, 460: y of the paddle's top edge.
- `PADDLE_STEP`, 8: paddle move per frame tick.
- `BALL_SPEED`, 2: ball move per axis per frame tick.
- `FRAME_DIV`, 833333: clocks per frame tick (60 Hz at 50 MHz).

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `ready_sig` in 1: one-cycle pulse; re-arm the game.
- `start_sig` in 1: one-cycle pulse; begin play.
- `play_sig` in 1: level; motion is enabled while high.
- `pause_sig` in 1: level; game over or held.
- `left_sig` in 1: paddle-left request; may be high on consecutive cycles.
- `right_sig` in 1: paddle-right request; may be high on consecutive cycles.
- `ball_x` out 10: ball left edge.
- `ball_y` out 10: ball top edge.
- `paddle_x` out 10: paddle left edge.
- `score` out 8: paddle hits since arm; saturates at 255.
- `sig_dead` out 1: one-cycle pulse on a miss.
- `running` out 1: high in state RUN.

## Operation

**State machine** (encoding 2 bits): IDLE, ARMED, RUN, DEAD.
- **IDLE**
  - `ready_sig` → ARMED.
- **ARMED**
  - On entry: `ball_x`=316, `ball_y`=240, dx=+1 (right), dy=+1 (down), `paddle_x`=288, `score`=0, move requests cleared.
  - `start_sig` → RUN.
- **RUN**
  - Updates occur only on a frame tick with `play_sig`=1.
  - `pause_sig`=1 or `play_sig`=0 freezes motion; the state stays RUN.
- **DEAD**
  - Positions are frozen.
  - `ready_sig` → ARMED.
- `ready_sig` in any state → ARMED, with the entry actions above. This takes priority over every other event.

**Move requests**
- `left_sig` sets `left_req`; `right_sig` sets `right_req`.
- Both flags clear on every frame tick and on `ready_sig`.

**Per tick in RUN**
- Paddle:
  - `left_req` only: `paddle_x` -= `PADDLE_STEP`, clamped at 0.
  - `right_req` only: `paddle_x` += `PADDLE_STEP`, clamped at `SCREEN_W`-`PADDLE_W` (576).
  - Both or neither: no move.
- Ball x:
  - Compute next = x ± `BALL_SPEED`.
  - If next ≥ 632 (`SCREEN_W`-`BALL_SIZE`): clamp to 632 and set dx=-1.
  - If next would go below 0: clamp to 0 and set dx=+1.
- Ball y, moving up:
  - If `ball_y` ≤ `BALL_SPEED`: `ball_y`=0, dy=+1.
- Ball y, moving down, when next+`BALL_SIZE` ≥ `PADDLE_Y`:
  - Hit when `ball_x`+`BALL_SIZE` > `paddle_x` and `ball_x` < `paddle_x`+`PADDLE_W`.
  - Both sides use the pre-tick registered values.
  - On hit: `ball_y`=452, dy=-1, `score`+1 (saturating).
  - On miss: `ball_y`=next, `sig_dead` pulse, → DEAD.
- Arithmetic is done in 11 bits signed internally to avoid wrap; outputs are 10 bits unsigned.

## Timing

**Reset values**
- State IDLE.
- `ball_x`=316, `ball_y`=240, `paddle_x`=288.
- `score`=0, `sig_dead`=0, `running`=0.
- Tick counter=0; requests cleared.

**Frame tick**
- Free-running counter, 0..`FRAME_DIV`-1.
- Tick is high for one cycle when the counter equals `FRAME_DIV`-1.

**Latency**
- Registered outputs change on the clock edge that samples the tick.
- `sig_dead` is high for exactly the one cycle following that edge.
- `start_sig` at cycle n → `running`=1 at n+1.

**Boundary cases**
- `ready_sig` on the same cycle as a tick: the re-arm wins and the tick is discarded.
- `left_sig` coincident with a tick: it is applied on this tick. The flag set and the clear resolve as set-then-consume.
- Corner hit (x-wall and paddle on the same tick): both reflections apply.
- Reset mid-game: immediate asynchronous return to the reset values.

## Structure

**Shared package `pong_pkg`**
- Screen and paddle constants.
- State encoding (IDLE=0, ARMED=1, RUN=2, DEAD=3).
- Derived limits: `BALL_X_MAX`=632, `PADDLE_X_MAX`=576.

**Sub-module `frame_tick_gen`**
- Parameter `FRAME_DIV`.
- Ports `clk`, `reset`, `tick`.
- Internally it is the modulo counter only.

## Test plan

All scenarios use `FRAME_DIV`=4.

1. **Reset then arm.** Assert `reset`, then pulse `ready_sig` → `ball_x`=316, `ball_y`=240, `paddle_x`=288, `score`=0, `running`=0.
2. **Start and first tick.** `start_sig`, `play_sig`=1, one tick → `ball_x`=318, `ball_y`=242.
3. **Right wall bounce.** Hold `right_sig` for 100 ticks → `paddle_x` saturates at 576. Separately, ball at x=631 moving right → x=632, dx=-1, next tick x=630.
4. **Paddle hit.** `ball_x`=300, `ball_y`=450 moving down, `paddle_x`=288 → `ball_y`=452, dy up, `score`=1, no `sig_dead`.
5. **Miss.** `ball_x`=100, `ball_y`=450 moving down, `paddle_x`=288 → `sig_dead` for exactly one cycle, state DEAD, positions frozen over the next 10 ticks.
6. **Re-arm and pause.** From DEAD, `ready_sig` → ARMED with reset positions. In RUN with `play_sig`=0 for 5 ticks → no position change.
